servant_wb_rr_arbiter: RTL and testbench

SERVANT_WB_RR_ARBITER -- requirements
Module: servant_wb_rr_arbiter

---
 rtl/servant_wb_rr_arbiter.sv | 114 +++++++++++
 tb/tb_servant_wb_rr_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/servant_wb_rr_arbiter.sv
// Three-master round-robin Wishbone arbiter with a per-transaction timeout.
// A master owns the slave from grant until ack, abort (cyc drop), timeout or reset.
module servant_wb_rr_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [95:0] i_wb_m_adr,
    input  logic [95:0] i_wb_m_dat,
    input  logic [11:0] i_wb_m_sel,
    input  logic [2:0]  i_wb_m_we,
    input  logic [2:0]  i_wb_m_cyc,
    output logic [31:0] o_wb_m_rdt,
    output logic [2:0]  o_wb_m_ack,
    output logic [2:0]  o_wb_m_err,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic [2:0]  o_grant,
    output logic [7:0]  o_err_cnt
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [2:0] grant_nxt;
    logic [1:0] last, last_nxt;
    logic [7:0] tcnt, tcnt_nxt;
    logic [7:0] ecnt_nxt;
    logic [1:0] idx, pick;
    logic       in_grant, m_cyc, timeout;

    always_comb begin
        unique case (o_grant)
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
    end

    // Search from last+3 down to last+1 so the nearest successor wins.
    always_comb begin
        pick = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            if (i_wb_m_cyc[(int'(last) + k) % 3])
                pick = 2'((int'(last) + k) % 3);
        end
    end

    assign in_grant = (state == GRANT);
    assign m_cyc    = i_wb_m_cyc[idx];
    // Ack wins over timeout; an aborting master gets no error.
    assign timeout  = in_grant & m_cyc & ~i_wb_ack & (tcnt == TO_LAST);

    assign o_wb_adr   = i_wb_m_adr[{idx, 5'd0} +: 32];
    assign o_wb_dat   = i_wb_m_dat[{idx, 5'd0} +: 32];
    assign o_wb_sel   = i_wb_m_sel[{idx, 2'd0} +: 4];
    assign o_wb_we    = i_wb_m_we[idx];
    assign o_wb_cyc   = in_grant & m_cyc & ~timeout & ~i_rst;
    assign o_wb_m_ack = {3{i_wb_ack & in_grant & ~i_rst}} & o_grant;
    assign o_wb_m_err = {3{timeout & ~i_rst}} & o_grant;
    assign o_wb_m_rdt = i_wb_rdt;

    always_comb begin
        state_nxt = state;
        grant_nxt = o_grant;
        last_nxt  = last;
        tcnt_nxt  = tcnt;
        ecnt_nxt  = o_err_cnt;
        unique case (state)
            IDLE: begin
                grant_nxt = 3'b000;
                if (|i_wb_m_cyc) begin
                    grant_nxt = 3'(3'b001 << pick);
                    state_nxt = GRANT;
                    tcnt_nxt  = 8'd0;
                end
            end
            GRANT: begin
                if (i_wb_ack || !m_cyc || timeout) begin
                    state_nxt = IDLE;
                    grant_nxt = 3'b000;
                    last_nxt  = idx;
                    if (timeout && o_err_cnt != 8'hff)
                        ecnt_nxt = o_err_cnt + 8'd1;
                end else begin
                    tcnt_nxt = tcnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            o_grant   <= 3'b000;
            last      <= 2'd2;
            tcnt      <= 8'd0;
            o_err_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            o_grant   <= grant_nxt;
            last      <= last_nxt;
            tcnt      <= tcnt_nxt;
            o_err_cnt <= ecnt_nxt;
        end
    end
endmodule

// File: tb/tb_servant_wb_rr_arbiter.sv
// Scoreboard bench: driver predicts each transaction's winner and outcome,
// monitor pops and compares whenever an ack or err appears.
module tb_servant_wb_rr_arbiter;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] m_adr, m_dat;
    logic [11:0] m_sel;
    logic [2:0]  m_we, m_cyc;
    logic [31:0] m_rdt;
    logic [2:0]  m_ack, m_err;
    logic [31:0] s_adr, s_dat;
    logic [3:0]  s_sel;
    logic        s_we, s_cyc;
    logic [31:0] s_rdt;
    logic        s_ack;
    logic [2:0]  grant;
    logic [7:0]  err_cnt;

    servant_wb_rr_arbiter #(.TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_m_adr(m_adr), .i_wb_m_dat(m_dat), .i_wb_m_sel(m_sel),
        .i_wb_m_we(m_we), .i_wb_m_cyc(m_cyc),
        .o_wb_m_rdt(m_rdt), .o_wb_m_ack(m_ack), .o_wb_m_err(m_err),
        .o_wb_adr(s_adr), .o_wb_dat(s_dat), .o_wb_sel(s_sel), .o_wb_we(s_we),
        .o_wb_cyc(s_cyc), .i_wb_rdt(s_rdt), .i_wb_ack(s_ack),
        .o_grant(grant), .o_err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  grant;
        logic        is_err;
        logic [31:0] rdt;
        logic [31:0] adr;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sbq[$];
    exp_t        me;
    int          checks = 0;
    int          errors = 0;
    int          m_last = 2;
    int          m_cnt  = 0;
    logic [31:0] adr_v[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Nearest requester after the last granted one, wrapping 2 -> 0.
    function automatic int rr_pick(input int last, input logic [2:0] mask);
        for (int k = 1; k <= 3; k++)
            if (mask[(last + k) % 3]) return (last + k) % 3;
        return 0;
    endfunction

    always @(negedge clk) begin
        if ((|m_ack) || (|m_err)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_resp", 32'({m_ack, m_err}), 32'd0);
            end else begin
                me = sbq.pop_front();
                chk("grant", 32'(grant), 32'(me.grant));
                chk("ack", 32'(m_ack), me.is_err ? 32'd0 : 32'(me.grant));
                chk("err", 32'(m_err), me.is_err ? 32'(me.grant) : 32'd0);
                chk("slave_cyc", 32'(s_cyc), me.is_err ? 32'd0 : 32'd1);
                chk("slave_adr", s_adr, me.adr);
                if (!me.is_err) chk("rdt", m_rdt, me.rdt);
                chk("err_cnt", 32'(err_cnt), 32'(me.cnt));
            end
        end
    end

    task automatic set_masters();
        for (int i = 0; i < 3; i++) adr_v[i] = $urandom;
        m_adr = {adr_v[2], adr_v[1], adr_v[0]};
        m_dat = {$urandom, $urandom, $urandom};
        m_sel = 12'($urandom);
        m_we  = 3'($urandom);
    endtask

    // kind 0: ack in grant cycle d+1; kind 1: never ack (timeout); kind 2: abort in cycle d.
    task automatic txn(input logic [2:0] mask, input int kind, input int d);
        int          w;
        logic [31:0] rdt;
        set_masters();
        w   = rr_pick(m_last, mask);
        rdt = $urandom;
        @(posedge clk); #1;
        m_cyc = mask;
        if (kind == 0) sbq.push_back('{3'(1 << w), 1'b0, rdt, adr_v[w], 8'(m_cnt)});
        if (kind == 1) begin
            sbq.push_back('{3'(1 << w), 1'b1, 32'd0, adr_v[w], 8'(m_cnt)});
            if (m_cnt < 255) m_cnt++;
        end
        m_last = w;
        for (int j = 1; j <= TO; j++) begin
            @(posedge clk); #1;
            if (kind == 0 && j == d + 1) begin
                s_rdt = rdt;
                s_ack = 1'b1;
                break;
            end
            if (kind == 2 && j == d) begin
                m_cyc = 3'b000;
                break;
            end
        end
        @(posedge clk); #1;
        s_ack = 1'b0;
        m_cyc = 3'b000;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; m_cyc = 3'b111; s_ack = 1'b1; s_rdt = 32'd0;
        set_masters();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cyc", 32'(s_cyc), 32'd0);
        chk("rst_ack", 32'(m_ack), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0; m_cyc = 3'b000; s_ack = 1'b0;

        // Directed cases
        txn(3'b010, 0, 2);
        txn(3'b100, 1, 0);
        txn(3'b001, 0, TO - 1);
        txn(3'b001, 2, 1);
        txn(3'b011, 0, 0);

        // All three held: rotation with slave acking every granted cycle
        set_masters();
        for (int n = 0; n < 6; n++) begin
            int w;
            w = rr_pick(m_last, 3'b111);
            sbq.push_back('{3'(1 << w), 1'b0, 32'hcafe_f00d, adr_v[w], 8'(m_cnt)});
            m_last = w;
        end
        @(posedge clk); #1;
        m_cyc = 3'b111; s_rdt = 32'hcafe_f00d;
        for (int t = 0; t < 40 && sbq.size() > 0; t++) begin
            @(posedge clk); #1;
            s_ack = s_cyc;
        end
        s_ack = 1'b0; m_cyc = 3'b000;
        chk("rotation_done", 32'(sbq.size()), 32'd0);
        sbq.delete();

        // Reset in the middle of a grant, with the slave acking
        @(posedge clk); #1;
        m_cyc = 3'b010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; s_ack = 1'b1;
        @(negedge clk);
        chk("midrst_cyc", 32'(s_cyc), 32'd0);
        chk("midrst_ack", 32'(m_ack), 32'd0);
        chk("midrst_err", 32'(m_err), 32'd0);
        @(posedge clk); #1;
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0; s_ack = 1'b0; m_cyc = 3'b000;
        m_last = 2; m_cnt = 0;
        txn(3'b111, 0, 0);

        // Random mix
        for (int n = 0; n < 120; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            if (kind == 0)      txn(3'($urandom_range(1, 7)), 0, $urandom_range(0, TO - 1));
            else if (kind == 1) txn(3'($urandom_range(1, 7)), 1, 0);
            else                txn(3'($urandom_range(1, 7)), 2, $urandom_range(1, TO - 1));
        end

        // Saturation of the error counter
        for (int n = 0; n < 300; n++) txn(3'($urandom_range(1, 7)), 1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("err_cnt_sat", 32'(err_cnt), 32'(m_cnt));
        chk("err_cnt_255", 32'(err_cnt), 32'd255);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
